// File: rtl/sc_ifu.sv
// sc_ifu: single-cycle instruction fetch unit.
// Holds the PC, presents the fetched instruction to the datapath,
// selects the next PC from the control unit's pcsource and counts
// retired instructions. A jump-to-self parks the unit in HALT.
module sc_ifu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic [1:0]  pcsource,
   input  logic [31:0] ra,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] inst,
   output logic [5:0]  op,
   output logic [5:0]  func,
   output logic [15:0] imm,
   output logic        inst_valid,
   output logic [31:0] icount,
   output logic        halted,
   output logic        misalign
);

   // The reset PC is always word aligned, whatever the parameter says.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        retire;
   logic [31:0] next_pc;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        jr_misaligned;

   assign pc4       = pc + 32'd4;
   assign imem_addr = pc;
   assign halted    = (state == HALT);
   assign op        = inst[31:26];
   assign func      = inst[5:0];
   assign imm       = inst[15:0];

   assign branch_target = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
   assign jump_target   = {pc4[31:28], inst[25:0], 2'b00};
   assign jr_misaligned = (ra[1:0] != 2'b00);

   // Instruction presentation, retire decision, next-PC mux and next state.
   always_comb begin
      state_next = state;
      inst_valid = 1'b0;
      inst       = 32'h0000_0000;
      retire     = 1'b0;
      next_pc    = pc;
      if (!reset && state == RUN) begin
         inst_valid = imem_ready;
         if (imem_ready) begin
            inst = imem_rdata;
         end
         retire = imem_ready && !stall;
      end
      case (pcsource)
         2'b00:   next_pc = pc4;
         2'b01:   next_pc = branch_target;
         2'b10:   next_pc = {ra[31:2], 2'b00};
         default: next_pc = jump_target;
      endcase
      case (state)
         BOOT:    state_next = RUN;
         RUN: begin
            if (retire && pcsource == 2'b11 && jump_target == pc) begin
               state_next = HALT;
            end
         end
         HALT:    state_next = HALT;
         default: state_next = BOOT;
      endcase
   end

   // State register, PC, retire counter and sticky misalign flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= BOOT;
         pc       <= RESET_PC_ALIGNED;
         icount   <= 32'h0000_0000;
         misalign <= 1'b0;
      end else begin
         state <= state_next;
         if (retire) begin
            pc     <= next_pc;
            icount <= icount + 32'd1;
            if (pcsource == 2'b10 && jr_misaligned) begin
               misalign <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/sc_ifu.md
SC_IFU -- requirements
Module: sc_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset; bits [1:0] SHALL be treated as 0.
REQ-002 clock  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  holds the PC and suppresses the retire for the current cycle.
REQ-005 imem_ready  input  1  instruction memory has valid data on imem_rdata this cycle.
REQ-006 imem_rdata  input  32  instruction word at imem_addr.
REQ-007 pcsource  input  2  next-PC select from the control unit: 00 pc+4, 01 branch, 10 jr, 11 j/jal.
REQ-008 ra  input  32  register-file read port A value, used as the jr target.
REQ-009 imem_addr  output  32  fetch address; SHALL equal pc.
REQ-010 pc, pc4  output  32 each  current PC and pc+4 (pc4 feeds the jal link path).
REQ-011 inst  output  32  current instruction; op=inst[31:26], func=inst[5:0], imm=inst[15:0] as separate outputs.
REQ-012 inst_valid  output  1  inst holds a real fetched instruction this cycle.
REQ-013 icount  output  32  retired-instruction counter.
REQ-014 halted, misalign  output  1 each  halt state indicator and sticky misaligned-jr flag.

Function
REQ-015 FSM states: BOOT, RUN, HALT; reset SHALL force BOOT.
REQ-016 BOOT SHALL last exactly one cycle with inst_valid=0, then go to RUN; pc SHALL stay at RESET_PC.
REQ-017 In RUN, inst_valid SHALL be imem_ready; inst SHALL be imem_rdata when inst_valid=1, else 32'h0 (NOP), combinationally.
REQ-018 Retire condition: state RUN & imem_ready & ~stall; only then SHALL pc load next-PC and icount increment by 1.
REQ-019 Without retire, pc and icount SHALL hold; pcsource SHALL be ignored.
REQ-020 pcsource=00: next = pc+4.
REQ-021 pcsource=01: next = pc4 + {sign-extended imm[15:0], 2'b00}; all adds modulo 2^32 (wrap, no flag).
REQ-022 pcsource=10: next = {ra[31:2], 2'b00}; if ra[1:0]!=0, misalign SHALL set on that retire and stay 1 until reset.
REQ-023 pcsource=11: next = {pc4[31:28], inst[25:0], 2'b00}.
REQ-024 A retire with pcsource=11 whose computed target equals pc (jump-to-self) SHALL move the FSM to HALT, with pc unchanged.
REQ-025 In HALT: inst_valid=0, inst=0, halted=1, pc and icount frozen; only reset exits.
REQ-026 icount SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 stall and imem_ready SHALL be ignored in BOOT and HALT.

Reset
REQ-028 On reset high at a rising edge: pc=RESET_PC, icount=0, misalign=0, halted=0, state=BOOT, regardless of stall/imem_ready/state.
REQ-029 During and the cycle after reset: inst_valid=0 and inst=0.
REQ-030 Reset asserted mid-stall or in HALT SHALL fully restart from BOOT.

Verification
REQ-031 Reset, imem_ready=1, pcsource=00, 3 cycles after BOOT -> pc 0,4,8,12; icount=3.
REQ-032 pc=0x40, imm=16'hFFFE, pcsource=01, retire -> pc=0x3C; imm=16'h0003 from pc=0x40 -> pc=0x50.
REQ-033 pc=0x1000_0000, inst[25:0]=26'h0000010, pcsource=11 -> pc=0x1000_0040; ra=0x123 with pcsource=10 -> pc=0x120, misalign=1 and stays 1.
REQ-034 stall=1 for 2 cycles at pc=0x8 -> pc=0x8, icount unchanged; imem_ready=0 -> inst=0, inst_valid=0, pc held.
REQ-035 inst=32'h0800_0004 at pc=0x10, pcsource=11 -> halted=1 next cycle, pc=0x10, icount frozen; reset -> pc=RESET_PC, halted=0.
REQ-036 pc=0xFFFF_FFFC, pcsource=00 -> pc=0x0; icount forced near 32'hFFFF_FFFF wraps to 0.
